// File: rtl/factorial_pkg.sv
// factorial_pkg: shared register offsets, opdone codes, FSM state type and Booth digit encoder.
`default_nettype none

package factorial_pkg;

  localparam int RES_W = 128;

  localparam logic [7:0] OFS_OPSTART  = 8'h00;
  localparam logic [7:0] OFS_OPCLEAR  = 8'h08;
  localparam logic [7:0] OFS_OPDONE   = 8'h10;
  localparam logic [7:0] OFS_INTREN   = 8'h18;
  localparam logic [7:0] OFS_OPERAND  = 8'h20;
  localparam logic [7:0] OFS_RESULT_H = 8'h28;
  localparam logic [7:0] OFS_RESULT_L = 8'h30;

  localparam logic [1:0] OPDONE_IDLE = 2'b00;
  localparam logic [1:0] OPDONE_BUSY = 2'b10;
  localparam logic [1:0] OPDONE_DONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Radix-4 Booth recoding of {b[2i+1], b[2i], b[2i-1]} -> {negate, times2, times1}.
  function automatic logic [2:0] booth_enc(input logic [2:0] grp);
    case (grp)
      3'b001, 3'b010: booth_enc = 3'b001;
      3'b011:         booth_enc = 3'b010;
      3'b100:         booth_enc = 3'b110;
      3'b101, 3'b110: booth_enc = 3'b101;
      default:        booth_enc = 3'b000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/factorial_core_booth_mul.sv
// booth_mul: sequential radix-4 Booth multiplier, unsigned MC_W x MP_W -> MC_W product, start/done handshake.
// FACTO_OVERFLOW_EN widens the accumulator so o_ovf flags products that do not fit in MC_W bits.
`default_nettype none

module booth_mul #(
  parameter int MC_W = 128,
  parameter int MP_W = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [MC_W-1:0] i_mcand,
  input  logic [MP_W-1:0] i_mplr,
  output logic            o_busy,
  output logic            o_done,
  output logic [MC_W-1:0] o_product,
  output logic            o_ovf
);
  import factorial_pkg::*;

`ifdef FACTO_OVERFLOW_EN
  localparam int AW = MC_W + MP_W + 2;
`else
  // Two's-complement sums stay exact modulo 2^MC_W, so no guard bits are needed.
  localparam int AW = MC_W;
`endif
  // Multiplier is zero-extended by two bits so the unsigned operand gets one extra digit.
  localparam int NDIG = MP_W / 2 + 1;
  localparam int CW   = $clog2(NDIG);

  logic [AW-1:0]   r_acc;
  logic [AW-1:0]   r_mcand;
  logic [MP_W+2:0] r_mplr;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [2:0]      w_enc;
  logic [AW-1:0]   w_mag;
  logic [AW-1:0]   w_pp;

  always_comb begin
    w_enc = booth_enc(r_mplr[2:0]);
    w_mag = '0;
    if (w_enc[0])      w_mag = r_mcand;
    else if (w_enc[1]) w_mag = {r_mcand[AW-2:0], 1'b0};
    w_pp = w_enc[2] ? (~w_mag + AW'(1)) : w_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_acc   <= '0;
      r_mcand <= AW'(i_mcand);
      r_mplr  <= {2'b00, i_mplr, 1'b0};
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_busy) begin
      r_acc   <= r_acc + w_pp;
      r_mcand <= {r_mcand[AW-3:0], 2'b00};
      r_mplr  <= {2'b00, r_mplr[MP_W+2:2]};
      r_cnt   <= r_cnt + CW'(1);
      if (r_cnt == CW'(NDIG - 1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_acc[MC_W-1:0];
`ifdef FACTO_OVERFLOW_EN
  assign o_ovf = |r_acc[AW-1:MC_W];
`else
  assign o_ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/factorial_core.sv
// factorial_core: memory-mapped N! accelerator (register file, decode, FSM, interrupt).
// Optional sticky overflow flag in opdone[2] via FACTO_OVERFLOW_EN (implemented in booth_mul).
`default_nettype none

module factorial_core #(
  parameter logic [7:0] BASE_HI = 8'h70,
  parameter int         RES_W   = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_sel,
  input  logic        s_wr,
  input  logic [15:0] s_addr,
  input  logic [63:0] s_din,
  output logic [63:0] s_dout,
  output logic        interrupt
);
  import factorial_pkg::*;

  state_t             r_state, w_state_nxt;
  logic               r_opstart, r_opclear, r_intren, r_ovf;
  logic [63:0]        r_operand, r_cnt;
  logic [RES_W-1:0]   r_result;

  logic               w_wr, w_rd, w_start, w_clr, w_busy;
  logic [7:0]         w_ofs;
  logic [63:0]        w_cnt_dec;
  logic [1:0]         w_opdone;
  logic [127:0]       w_res128;
  logic               w_mul_start, w_mul_busy, w_mul_done, w_mul_ovf;
  logic [RES_W-1:0]   w_mul_prod;

  assign w_ofs     = s_addr[7:0];
  assign w_wr      = s_sel && s_wr && (s_addr[15:8] == BASE_HI);
  assign w_rd      = s_sel && !s_wr && (s_addr[15:8] == BASE_HI);
  assign w_busy    = (r_state == ST_INIT) || (r_state == ST_MUL);
  assign w_start   = w_wr && (w_ofs == OFS_OPSTART) && s_din[0] && (r_state == ST_IDLE);
  // The written opclear bit keeps clearing for its one readable cycle so it beats any opstart.
  assign w_clr     = (w_wr && (w_ofs == OFS_OPCLEAR) && s_din[0]) || r_opclear;
  assign w_cnt_dec = r_cnt - 64'd1;
  assign w_res128  = 128'(r_result);
  assign w_mul_start = (r_state == ST_MUL) && !w_mul_busy && !w_mul_done;
  assign interrupt = r_intren && (r_state == ST_DONE);

  booth_mul #(
    .MC_W(RES_W),
    .MP_W(64)
  ) u_mul (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_start  (w_mul_start),
    .i_abort  (w_clr),
    .i_mcand  (r_result),
    .i_mplr   (r_cnt),
    .o_busy   (w_mul_busy),
    .o_done   (w_mul_done),
    .o_product(w_mul_prod),
    .o_ovf    (w_mul_ovf)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_opdone    = OPDONE_IDLE;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_INIT;
      ST_INIT: begin
        w_opdone    = OPDONE_BUSY;
        w_state_nxt = (r_cnt <= 64'd1) ? ST_DONE : ST_MUL;
      end
      ST_MUL: begin
        w_opdone = OPDONE_BUSY;
        if (w_mul_done && (w_cnt_dec <= 64'd1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_opdone = OPDONE_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_clr) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_opstart <= 1'b0;
      r_opclear <= 1'b0;
      r_intren  <= 1'b0;
      r_ovf     <= 1'b0;
      r_operand <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_opclear <= w_wr && (w_ofs == OFS_OPCLEAR) && s_din[0];
      if (w_wr && (w_ofs == OFS_INTREN)) r_intren <= s_din[0];
      if (w_wr && (w_ofs == OFS_OPERAND) && !w_busy) r_operand <= s_din;
      if (w_clr) begin
        r_opstart <= 1'b0;
        r_result  <= '0;
        r_ovf     <= 1'b0;
      end else begin
        if (w_start) begin
          r_opstart <= 1'b1;
          r_cnt     <= r_operand;
        end
        if (r_state == ST_INIT) r_result <= RES_W'(1);
        if ((r_state == ST_MUL) && w_mul_done) begin
          r_result <= w_mul_prod;
          r_cnt    <= w_cnt_dec;
          r_ovf    <= r_ovf | w_mul_ovf;
        end
      end
    end
  end

  always_comb begin
    s_dout = '0;
    if (w_rd) begin
      case (w_ofs)
        OFS_OPSTART:  s_dout = {63'd0, r_opstart};
        OFS_OPCLEAR:  s_dout = {63'd0, r_opclear};
        OFS_OPDONE:   s_dout = {61'd0, r_ovf, w_opdone};
        OFS_INTREN:   s_dout = {63'd0, r_intren};
        OFS_OPERAND:  s_dout = r_operand;
        OFS_RESULT_H: s_dout = w_res128[127:64];
        OFS_RESULT_L: s_dout = w_res128[63:0];
        default:      s_dout = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_factorial_core.sv
// tb_factorial_core: directed + randomized self-checking bench for factorial_core.
`default_nettype none
`timescale 1ns/1ps

module tb_factorial_core;

  localparam logic [7:0] A_START = 8'h00, A_CLEAR = 8'h08, A_DONE = 8'h10, A_INTEN = 8'h18;
  localparam logic [7:0] A_OPND  = 8'h20, A_RESH  = 8'h28, A_RESL = 8'h30;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_sel = 1'b0;
  logic        s_wr = 1'b0;
  logic [15:0] s_addr = '0;
  logic [63:0] s_din = '0;
  logic [63:0] s_dout;
  logic        interrupt;

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  factorial_core dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_sel    (s_sel),
    .s_wr     (s_wr),
    .s_addr   (s_addr),
    .s_din    (s_din),
    .s_dout   (s_dout),
    .interrupt(interrupt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact n! in wide arithmetic; the register holds the low 128 bits.
  function automatic logic [255:0] fact_full(input int n);
    logic [255:0] f;
    f = 256'd1;
    for (int i = 2; i <= n; i++) f = f * 256'(i);
    return f;
  endfunction

  task automatic bus_wr(input logic [7:0] ofs, input logic [63:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = {8'h70, ofs}; s_din = d;
    @(negedge clk);
    s_sel = 1'b0; s_wr = 1'b0; s_din = '0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [63:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
    #1 d = s_dout;
    s_sel = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic [63:0] d;
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      bus_rd({8'h70, A_DONE}, d);
      if (d[1:0] == 2'b11) ok = 1'b1;
    end
    check({tag, "_finished"}, {127'd0, ok}, 128'd1);
  endtask

  task automatic run_op(input int n, input string tag);
    logic [255:0] full;
    logic [63:0]  rh, rl, od;
    logic         ovf;
    full = fact_full(n);
`ifdef FACTO_OVERFLOW_EN
    ovf = |full[255:128];
`else
    ovf = 1'b0;
`endif
    bus_wr(A_CLEAR, 64'd1);
    bus_wr(A_OPND, 64'(n));
    bus_wr(A_START, 64'd1);
    wait_done(tag);
    bus_rd({8'h70, A_DONE}, od);
    bus_rd({8'h70, A_RESH}, rh);
    bus_rd({8'h70, A_RESL}, rl);
    check({tag, "_opdone"}, {64'd0, od}, {125'd0, ovf, 2'b11});
    check({tag, "_result"}, {rh, rl}, full[127:0]);
  endtask

  initial begin
    logic [63:0] d, rh, rl;
    longint t0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_interrupt", {127'd0, interrupt}, 128'd0);
    check("rst_dout_idle", {64'd0, s_dout}, 128'd0);
    @(negedge clk) reset_n = 1'b1;
    bus_rd({8'h70, A_DONE}, d);  check("rst_opdone", {64'd0, d}, 128'd0);
    bus_rd({8'h70, A_RESL}, d);  check("rst_result_l", {64'd0, d}, 128'd0);
    bus_rd({8'h70, A_OPND}, d);  check("rst_operand", {64'd0, d}, 128'd0);

    // 20! with interrupt enabled and latency bound
    bus_wr(A_INTEN, 64'd1);
    bus_wr(A_OPND, 64'd20);
    t0 = cyc;
    bus_wr(A_START, 64'd1);
    wait_done("f20");
    check("f20_latency_le_700", {127'd0, (cyc - t0) <= 700}, 128'd1);
    bus_rd({8'h70, A_RESL}, rl); check("f20_result_l", {64'd0, rl}, {64'd0, 64'h21C3677C82B40000});
    bus_rd({8'h70, A_RESH}, rh); check("f20_result_h", {64'd0, rh}, 128'd0);
    check("f20_interrupt", {127'd0, interrupt}, 128'd1);
    bus_rd({8'h70, A_START}, d); check("f20_opstart_rb", {64'd0, d}, 128'd1);

    // opclear keeps operand and intrEn
    bus_wr(A_CLEAR, 64'd1);
    @(negedge clk);
    bus_rd({8'h70, A_DONE}, d);  check("clr_opdone", {64'd0, d}, 128'd0);
    bus_rd({8'h70, A_RESL}, d);  check("clr_result_l", {64'd0, d}, 128'd0);
    check("clr_interrupt", {127'd0, interrupt}, 128'd0);
    bus_rd({8'h70, A_OPND}, d);  check("clr_operand_kept", {64'd0, d}, 128'd20);
    bus_rd({8'h70, A_INTEN}, d); check("clr_intren_kept", {64'd0, d}, 128'd1);
    bus_rd({8'h70, A_CLEAR}, d); check("clr_selfclear", {64'd0, d}, 128'd0);

    // Small N, boundaries and full-width 34!
    run_op(0, "n0");
    run_op(1, "n1");
    run_op(5, "n5");
    bus_rd({8'h70, A_RESL}, d);  check("n5_const", {64'd0, d}, 128'd120);
    run_op(34, "n34");
    bus_rd({8'h70, A_RESH}, rh);
    bus_rd({8'h70, A_RESL}, rl);
    check("n34_const", {rh, rl}, 128'hDE1BC4D19EFCAC82445DA75B00000000);

    // Abort mid-run, stay idle, then restart
    bus_wr(A_CLEAR, 64'd1);
    bus_wr(A_OPND, 64'd20);
    bus_wr(A_START, 64'd1);
    repeat (100) @(negedge clk);
    bus_wr(A_CLEAR, 64'd1);
    repeat (2) @(negedge clk);
    bus_rd({8'h70, A_DONE}, d);  check("abort_opdone", {64'd0, d}, 128'd0);
    bus_rd({8'h70, A_RESL}, d);  check("abort_result_l", {64'd0, d}, 128'd0);
    check("abort_interrupt", {127'd0, interrupt}, 128'd0);
    repeat (60) @(negedge clk);
    bus_rd({8'h70, A_DONE}, d);  check("abort_stays_idle", {64'd0, d}, 128'd0);
    bus_rd({8'h70, A_RESL}, d);  check("abort_result_stays0", {64'd0, d}, 128'd0);
    bus_wr(A_START, 64'd1);
    wait_done("restart");
    bus_rd({8'h70, A_RESL}, d);  check("restart_result_l", {64'd0, d}, {64'd0, 64'h21C3677C82B40000});

    // Interrupt gating by intrEn
    bus_wr(A_CLEAR, 64'd1);
    bus_wr(A_INTEN, 64'd0);
    bus_wr(A_OPND, 64'd3);
    bus_wr(A_START, 64'd1);
    wait_done("n3");
    bus_rd({8'h70, A_RESL}, d);  check("n3_result_l", {64'd0, d}, 128'd6);
    check("n3_int_disabled", {127'd0, interrupt}, 128'd0);
    bus_wr(A_INTEN, 64'd1);
    check("n3_int_enabled", {127'd0, interrupt}, 128'd1);

    // Unmapped / wrong-base reads, ignored writes
    bus_rd(16'h7038, d);         check("rd_unmapped", {64'd0, d}, 128'd0);
    bus_rd(16'h6000, d);         check("rd_wrong_base", {64'd0, d}, 128'd0);
    bus_rd(16'h6020, d);         check("rd_wrong_base_opnd", {64'd0, d}, 128'd0);
    bus_wr(A_RESL, 64'hDEAD);
    bus_rd({8'h70, A_RESL}, d);  check("ro_write_ignored", {64'd0, d}, 128'd6);
    bus_wr(A_START, 64'd1);
    repeat (5) @(negedge clk);
    bus_rd({8'h70, A_DONE}, d);  check("start_in_done_ignored", {64'd0, d}, 128'd3);
    bus_wr(A_CLEAR, 64'd1);
    bus_wr(A_OPND, 64'd10);
    bus_wr(A_START, 64'd1);
    bus_wr(A_OPND, 64'd7);
    wait_done("n10");
    bus_rd({8'h70, A_OPND}, d);  check("busy_operand_ignored", {64'd0, d}, 128'd10);
    bus_rd({8'h70, A_RESL}, d);  check("n10_result_l", {64'd0, d}, 128'd3628800);

    // Overflow boundary (flag only in the overflow-enabled build)
    run_op(35, "n35");

    // Randomized N against the reference
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(0, 40));
      run_op(n, $sformatf("rnd%0d_n%0d", r, n));
    end

    // Asynchronous reset mid-operation
    bus_wr(A_CLEAR, 64'd1);
    bus_wr(A_OPND, 64'd20);
    bus_wr(A_START, 64'd1);
    repeat (50) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_interrupt", {127'd0, interrupt}, 128'd0);
    @(negedge clk) reset_n = 1'b1;
    bus_rd({8'h70, A_DONE}, d);  check("arst_opdone", {64'd0, d}, 128'd0);
    bus_rd({8'h70, A_OPND}, d);  check("arst_operand", {64'd0, d}, 128'd0);
    bus_rd({8'h70, A_INTEN}, d); check("arst_intren", {64'd0, d}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
